ddr_rd_arbiter: RTL and testbench
=================================

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 Parameter DDR_ADDR_W, default 32: DDR address width.
REQ-002 Parameter BURST_W, default 8: burst length and burst-count width.
REQ-003 Parameter TIMEOUT_CYC, default 65535: watchdog limit in cycles; used only when the watchdog is compiled in.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  4  level request per consumer (0 dbuf, 1 ibuf, 2 pbuf, 3 abuf); held high until granted.
REQ-007 req_st_addr / req_step  input  4 x DDR_ADDR_W  per-requester start address and stride.
REQ-008 req_burst / req_burst_num  input  4 x BURST_W  per-requester burst size and burst count.
REQ-009 req_done  input  4  one-cycle pulse per requester: consumer has written its last word.
REQ-010 grant  output  4  one-hot, one-cycle grant pulse.
REQ-011 ag_start  output  1  one-cycle start pulse to the address generator.
REQ-012 ag_done  input  1  one-cycle pulse from the address generator: all addresses issued.
REQ-013 ag_st_addr / ag_step  output  DDR_ADDR_W  latched descriptor fields.
REQ-014 ag_burst / ag_burst_num  output  BURST_W  latched descriptor fields.
REQ-015 ready_mux  output  2  index of the consumer that owns the ddr2 data/ready path.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky watchdog error flag.

Function
REQ-018 FSM states: IDLE, ISSUE, BUSY.
REQ-019 IDLE, any req high: pick the winner round-robin, searching from last+1 mod 4.
  - Register the winner as sel; latch its four descriptor fields into ag_*.
  - Pulse grant[sel]; go to ISSUE.
REQ-020 IDLE, no req: remain in IDLE; no outputs change.
REQ-021 ISSUE: assert ag_start for exactly one cycle; clear done flags; go to BUSY.
REQ-022 BUSY: set sticky flag a_f on ag_done and c_f on req_done[sel].
  - Leave when both are seen, in either order or in the same cycle.
  - On leaving: last <= sel, go to IDLE.
REQ-023 req_done pulses from non-selected requesters are ignored.
REQ-024 ag_done outside BUSY is ignored.
REQ-025 ready_mux equals sel from the grant cycle onward and holds through IDLE until the next grant.
REQ-026 ag_* fields remain stable from grant until the next grant.
REQ-027 Minimum spacing between grants is 3 cycles; no back-to-back grant without passing through IDLE.
REQ-028 req is sampled only in IDLE; a request dropped before grant is never granted.

Reset
REQ-029 Asynchronous assertion puts the FSM in IDLE, including mid-transfer, and sets last = 3 so requester 0 has first priority.
REQ-030 Output reset values: grant 0, ag_start 0, ag_* 0, ready_mux 0, busy 0, err 0; a_f, c_f and watchdog counter 0.
REQ-031 An in-flight transfer is abandoned on reset and is not re-issued.

Configuration
REQ-032 Macro DDR_ARB_WATCHDOG_EN, defined: 16-bit counter clears on BUSY entry and increments every BUSY cycle.
  - On reaching TIMEOUT_CYC: set err (sticky until reset), update last = sel, return to IDLE.
REQ-033 Macro DDR_ARB_WATCHDOG_EN, undefined: no counter is built, err is tied to 0, and BUSY waits indefinitely.

Verification
REQ-034 Reset release, req=0001, ag_done and req_done[0] 5 cycles after ag_start -> grant=0001, ag_start one cycle later, ready_mux=0, busy low again 1 cycle after the later done.
REQ-035 req=1111 held continuously -> grant order 0,1,2,3,0, each grant only after both dones of the previous transfer.
REQ-036 req_done[sel] arrives 4 cycles before ag_done, then repeat with both in the same cycle -> exit exactly 1 cycle after the later of the two pulses in both cases.
REQ-037 During BUSY with sel=2, pulse req_done[1] and ag_done -> FSM stays in BUSY until req_done[2].
REQ-038 Assert rst mid-BUSY with sel=3 -> all outputs at reset values immediately; next request from 0 and 3 simultaneously grants 0.
REQ-039 DDR_ARB_WATCHDOG_EN with TIMEOUT_CYC=20, withhold ag_done -> err=1 after 20 BUSY cycles and FSM in IDLE; with the macro undefined -> err stays 0 and busy stays 1.

Source files
------------

// File: rtl/ddr_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_arbiter_if
// Purpose  : Bundles the request, descriptor, grant and address-generator
//            signals of the DDR read arbiter.
// Modports : master - arbiter side (drives grant, ag_*, ready_mux, busy, err)
//            slave  - consumer / address-generator side (drives req, req_*,
//                     req_done, ag_done)
// Params   : DDR_ADDR_W - address width, BURST_W - burst field width
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_rd_arbiter_if #(
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8
);
  logic [3:0]                 req;
  logic [3:0][DDR_ADDR_W-1:0] req_st_addr;
  logic [3:0][DDR_ADDR_W-1:0] req_step;
  logic [3:0][BURST_W-1:0]    req_burst;
  logic [3:0][BURST_W-1:0]    req_burst_num;
  logic [3:0]                 req_done;
  logic [3:0]                 grant;
  logic                       ag_start;
  logic                       ag_done;
  logic [DDR_ADDR_W-1:0]      ag_st_addr;
  logic [DDR_ADDR_W-1:0]      ag_step;
  logic [BURST_W-1:0]         ag_burst;
  logic [BURST_W-1:0]         ag_burst_num;
  logic [1:0]                 ready_mux;
  logic                       busy;
  logic                       err;

  modport master (
    input  req, req_st_addr, req_step, req_burst, req_burst_num, req_done, ag_done,
    output grant, ag_start, ag_st_addr, ag_step, ag_burst, ag_burst_num,
           ready_mux, busy, err
  );

  modport slave (
    output req, req_st_addr, req_step, req_burst, req_burst_num, req_done, ag_done,
    input  grant, ag_start, ag_st_addr, ag_step, ag_burst, ag_burst_num,
           ready_mux, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_arbiter
// Purpose  : Round-robin arbiter granting one of four read consumers access to
//            the DDR address generator. The winner's descriptor is latched and
//            handed to the address generator; the transfer ends once both the
//            address generator and the selected consumer report done.
// Ports    : clk - clock (rising edge)
//            rst - asynchronous active-high reset
//            bus - ddr_rd_arbiter_if.master (req/descriptors/done inputs,
//                  grant/ag_*/ready_mux/busy/err outputs)
// Params   : DDR_ADDR_W, BURST_W, TIMEOUT_CYC (watchdog limit)
// Options  : DDR_ARB_WATCHDOG_EN - builds a BUSY watchdog that sets the sticky
//            err flag and abandons the transfer after TIMEOUT_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_rd_arbiter #(
  parameter int DDR_ADDR_W  = 32,
  parameter int BURST_W     = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input wire               clk,
  input wire               rst,
  ddr_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_sel;
  logic [1:0]            r_last;
  logic [1:0]            w_idx;
  logic [1:0]            w_win;
  logic                  w_any_req;
  logic                  w_grant_en;
  logic                  w_issue_en;
  logic                  w_exit_en;
  logic                  w_timeout;
  logic                  w_a_seen;
  logic                  w_c_seen;
  logic                  r_a_f;
  logic                  r_c_f;
  logic [3:0]            r_grant;
  logic                  r_ag_start;
  logic [DDR_ADDR_W-1:0] r_ag_st_addr;
  logic [DDR_ADDR_W-1:0] r_ag_step;
  logic [BURST_W-1:0]    r_ag_burst;
  logic [BURST_W-1:0]    r_ag_burst_num;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    w_any_req = 1'b0;
    w_win     = 2'd0;
    w_idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_any_req && bus.req[w_idx]) begin
        w_any_req = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  // A done counts if already flagged or arriving this cycle, so both pulses
  // landing in the same cycle still exit immediately.
  assign w_a_seen = r_a_f | bus.ag_done;
  assign w_c_seen = r_c_f | bus.req_done[r_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_issue_en  = 1'b0;
    w_exit_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue_en  = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if ((w_a_seen && w_c_seen) || w_timeout) begin
          w_exit_en   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel          <= 2'd0;
      r_last         <= 2'd3;
      r_a_f          <= 1'b0;
      r_c_f          <= 1'b0;
      r_grant        <= 4'd0;
      r_ag_start     <= 1'b0;
      r_ag_st_addr   <= '0;
      r_ag_step      <= '0;
      r_ag_burst     <= '0;
      r_ag_burst_num <= '0;
    end else begin
      r_grant    <= 4'd0;
      r_ag_start <= w_issue_en;
      if (w_grant_en) begin
        r_sel          <= w_win;
        r_grant        <= 4'b0001 << w_win;
        r_ag_st_addr   <= bus.req_st_addr[w_win];
        r_ag_step      <= bus.req_step[w_win];
        r_ag_burst     <= bus.req_burst[w_win];
        r_ag_burst_num <= bus.req_burst_num[w_win];
      end
      if (w_issue_en) begin
        r_a_f <= 1'b0;
        r_c_f <= 1'b0;
      end else if (r_state == S_BUSY) begin
        if (bus.ag_done)         r_a_f <= 1'b1;
        if (bus.req_done[r_sel]) r_c_f <= 1'b1;
      end
      if (w_exit_en) begin
        r_last <= r_sel;
      end
    end
  end

`ifdef DDR_ARB_WATCHDOG_EN
  localparam logic [15:0] c_wd_last = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_wd_cnt;
  logic        r_err;

  // Counter value equals completed BUSY cycles, so the limit is hit on the
  // TIMEOUT_CYC-th BUSY cycle.
  assign w_timeout = (r_state == S_BUSY) && (r_wd_cnt == c_wd_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wd_cnt <= 16'd0;
      end else if (r_state == S_BUSY) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
      end
      // A transfer that completes on the limit cycle is not an error.
      if (w_timeout && !(w_a_seen && w_c_seen)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign bus.err          = 1'b0;
`endif

  assign bus.grant        = r_grant;
  assign bus.ag_start     = r_ag_start;
  assign bus.ag_st_addr   = r_ag_st_addr;
  assign bus.ag_step      = r_ag_step;
  assign bus.ag_burst     = r_ag_burst;
  assign bus.ag_burst_num = r_ag_burst_num;
  assign bus.ready_mux    = r_sel;
  assign bus.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rd_arbiter
// Purpose  : Self-checking bench for ddr_rd_arbiter: vector table, randomized
//            transfers against a round-robin reference model, and hand-written
//            corner sequences (same-cycle dones, foreign dones, async reset,
//            watchdog with or without DDR_ARB_WATCHDOG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_arbiter;
  localparam int AW = 32;
  localparam int BW = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_rd_arbiter_if #(.DDR_ADDR_W(AW), .BURST_W(BW)) bus ();

  ddr_rd_arbiter #(
    .DDR_ADDR_W (AW),
    .BURST_W    (BW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] req;
    int         exp_win;
    int         da;
    int         dc;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int m_last;
  logic [AW-1:0] d_st   [4];
  logic [AW-1:0] d_step [4];
  logic [BW-1:0] d_burst[4];
  logic [BW-1:0] d_num  [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: first requester at or after last+1 (mod 4) with its bit set.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic load_desc(input bit rnd);
    for (int i = 0; i < 4; i++) begin
      d_st[i]    = rnd ? AW'($urandom) : {8'(i + 1), 24'h00A000};
      d_step[i]  = rnd ? AW'($urandom) : AW'(64 * (i + 1));
      d_burst[i] = rnd ? BW'($urandom) : BW'(16 + i);
      d_num[i]   = rnd ? BW'($urandom) : BW'(3 + i);
      bus.req_st_addr[i]   = d_st[i];
      bus.req_step[i]      = d_step[i];
      bus.req_burst[i]     = d_burst[i];
      bus.req_burst_num[i] = d_num[i];
    end
  endtask

  task automatic do_reset();
    bus.req      = 4'b0;
    bus.req_done = 4'b0;
    bus.ag_done  = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_last = 3;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (bus.grant != 4'b0) begin
        g = bus.grant;
        break;
      end
    end
    if (g == 4'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL grant_wait: got no grant, expected one within 10 cycles");
    end
  endtask

  // One complete transfer. Dones are pulsed da / dc cycles after the
  // ag_start cycle; the FSM must be idle exactly one cycle after the later one.
  task automatic xfer(input logic [3:0] reqv, input int exp, input int da, input int dc,
                      input bit hold, input bit noise, input string tag);
    logic [3:0]    g;
    logic [3:0]    sel_bit;
    logic [3:0]    ghost;
    logic [AW-1:0] e_st;
    logic [AW-1:0] e_step;
    logic [BW-1:0] e_burst;
    logic [BW-1:0] e_num;
    int            last_k;
    bit            bad;
    sel_bit = 4'b0001 << exp;
    e_st    = d_st[exp];
    e_step  = d_step[exp];
    e_burst = d_burst[exp];
    e_num   = d_num[exp];
    bus.req = reqv;
    wait_grant(g);
    chk({tag, ".grant"}, 64'(g), 64'(sel_bit));
    chk({tag, ".ready_mux"}, 64'(bus.ready_mux), 64'(exp));
    chk({tag, ".ag_desc"}, {bus.ag_st_addr, bus.ag_step}, {e_st, e_step});
    chk({tag, ".ag_burst"}, {bus.ag_burst, bus.ag_burst_num, bus.busy}, {e_burst, e_num, 1'b1});
    if (!hold) bus.req = 4'b0;
    bus.ag_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    bus.ag_done = 1'b0;
    chk({tag, ".ag_start"}, {bus.ag_start, bus.grant, bus.busy}, {1'b1, 4'b0, 1'b1});
    last_k = (da > dc) ? da : dc;
    bad    = 1'b0;
    ghost  = noise ? 4'($urandom) : 4'b0;
    for (int k = 0; k <= last_k; k++) begin
      if (!hold) bus.req = (k < last_k) ? ghost : 4'b0;
      bus.ag_done  = (k == da);
      bus.req_done = ((k == dc) ? sel_bit : 4'b0) | (noise ? (4'($urandom) & ~sel_bit) : 4'b0);
      if (noise) load_desc(1'b1);
      step();
      if (bus.ag_start || bus.grant != 4'b0) bad = 1'b1;
      if (k < last_k && !bus.busy) bad = 1'b1;
    end
    bus.ag_done  = 1'b0;
    bus.req_done = 4'b0;
    chk({tag, ".busy_held"}, 64'(bad), 64'(0));
    chk({tag, ".exit"}, 64'(bus.busy), 64'(0));
    chk({tag, ".stable"}, {bus.ag_st_addr, bus.ag_burst, bus.ready_mux},
        {e_st, e_burst, 2'(exp)});
    m_last = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish within 500000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[8];
    logic [3:0] g;
    logic [3:0] r_rand;
    bit         bad;

    tbl[0] = '{req: 4'b0001, exp_win: 0, da: 5, dc: 5};
    tbl[1] = '{req: 4'b1111, exp_win: 1, da: 0, dc: 4};
    tbl[2] = '{req: 4'b0101, exp_win: 2, da: 4, dc: 0};
    tbl[3] = '{req: 4'b1001, exp_win: 3, da: 3, dc: 3};
    tbl[4] = '{req: 4'b0110, exp_win: 1, da: 2, dc: 7};
    tbl[5] = '{req: 4'b1000, exp_win: 3, da: 1, dc: 0};
    tbl[6] = '{req: 4'b0011, exp_win: 0, da: 0, dc: 0};
    tbl[7] = '{req: 4'b0100, exp_win: 2, da: 6, dc: 2};

    bus.req = 4'b0;
    bus.req_done = 4'b0;
    bus.ag_done = 1'b0;
    load_desc(1'b0);
    do_reset();

    chk("reset.ctrl", {bus.grant, bus.ag_start, bus.ready_mux, bus.busy, bus.err}, 64'(0));
    chk("reset.desc", {bus.ag_st_addr, bus.ag_step, bus.ag_burst, bus.ag_burst_num}, 64'(0));

    // Idle with no request: nothing moves.
    step();
    step();
    chk("idle.no_req", {bus.grant, bus.busy, bus.ag_start}, 64'(0));

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].req, tbl[i].exp_win, tbl[i].da, tbl[i].dc, 1'b0, 1'b0,
           $sformatf("vec%0d", i));
    end

    // Randomized transfers against the round-robin model.
    for (int n = 0; n < 40; n++) begin
      r_rand = 4'($urandom_range(0, 15));
      if (r_rand == 4'b0) begin
        bus.req = 4'b0;
        bad = 1'b0;
        repeat (3) begin
          step();
          if (bus.grant != 4'b0 || bus.busy) bad = 1'b1;
        end
        chk("rnd.idle", {7'(bad), bus.ready_mux}, {7'(0), 2'(m_last)});
      end else begin
        load_desc(1'b1);
        xfer(r_rand, rr_pick(r_rand, m_last), int'($urandom_range(0, 8)),
             int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 1'b1,
             $sformatf("rnd%0d", n));
      end
    end
    bus.req = 4'b0;

    // All four requesting continuously: strict rotation 0,1,2,3,0.
    load_desc(1'b0);
    do_reset();
    for (int n = 0; n < 5; n++) begin
      xfer(4'b1111, n % 4, 1, 1, 1'b1, 1'b0, $sformatf("rot%0d", n));
    end
    bus.req = 4'b0;

    // Foreign req_done and ag_done do not end a transfer owned by requester 2.
    do_reset();
    bus.req = 4'b0100;
    wait_grant(g);
    chk("foreign.grant", 64'(g), 64'(4'b0100));
    bus.req = 4'b0;
    step();
    bus.req_done = 4'b0010;
    bus.ag_done  = 1'b1;
    step();
    bus.req_done = 4'b0;
    bus.ag_done  = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      step();
      if (!bus.busy) bad = 1'b1;
    end
    chk("foreign.stay_busy", 64'(bad), 64'(0));
    bus.req_done = 4'b0100;
    step();
    bus.req_done = 4'b0;
    chk("foreign.exit", 64'(bus.busy), 64'(0));

    // Asynchronous reset in the middle of a transfer owned by requester 3.
    do_reset();
    bus.req = 4'b1000;
    wait_grant(g);
    chk("arst.grant", 64'(g), 64'(4'b1000));
    bus.req = 4'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst.ctrl", {bus.grant, bus.ag_start, bus.ready_mux, bus.busy, bus.err}, 64'(0));
    chk("arst.desc", {bus.ag_st_addr, bus.ag_burst, bus.ag_burst_num}, 64'(0));
    step();
    rst = 1'b0;
    m_last = 3;
    bad = 1'b0;
    repeat (4) begin
      step();
      if (bus.grant != 4'b0 || bus.busy) bad = 1'b1;
    end
    chk("arst.no_reissue", 64'(bad), 64'(0));
    xfer(4'b1001, 0, 2, 2, 1'b0, 1'b0, "arst.next");

    // Watchdog: ag_done withheld.
    do_reset();
    bus.req = 4'b0001;
    wait_grant(g);
    bus.req = 4'b0;
    step();
    bus.req_done = 4'b0001;
    step();
    bus.req_done = 4'b0;
`ifdef DDR_ARB_WATCHDOG_EN
    bad = 1'b0;
    for (int c = 2; c < TO; c++) begin
      if (!bus.busy || bus.err) bad = 1'b1;
      step();
    end
    chk("wd.before_limit", {7'(bad), bus.busy, bus.err}, {7'(0), 1'b1, 1'b0});
    step();
    chk("wd.timeout", {bus.busy, bus.err}, {1'b0, 1'b1});
    m_last = 0;
    xfer(4'b0011, 1, 2, 2, 1'b0, 1'b0, "wd.after");
    chk("wd.sticky", 64'(bus.err), 64'(1));
`else
    bad = 1'b0;
    repeat (2 * TO) begin
      step();
      if (!bus.busy || bus.err) bad = 1'b1;
    end
    chk("wd.off_wait", 64'(bad), 64'(0));
    bus.ag_done = 1'b1;
    step();
    bus.ag_done = 1'b0;
    chk("wd.off_exit", {bus.busy, bus.err}, {1'b0, 1'b0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
